lcd_ctrl: RTL

Character-LCD (HD44780-compatible, DE2 16x2 module) write controller sitting directly downstream of the load/store unit's LCD register. It captures each word the CPU stores to the LCD MMIO address (signalled by the LSU's `o_lcd_vld` strobe together with `o_io_lcd`) into a small FIFO. It replays each captured word to the panel with correctly timed address-setup, `LCD_EN` pulse, hold and command-execution wait, so software never bit-bangs `EN` or polls busy.

---
 rtl/singlecycle_pkg.sv | 27 ++
 rtl/lcd_fifo.sv | 57 +++++
 rtl/lcd_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/singlecycle_pkg.sv
// Shared definitions for the single-cycle core's LCD write path: register bit layout,
// panel command codes and the controller state type.
package singlecycle_pkg;

  localparam int unsigned LCD_DATA_LSB = 0;
  localparam int unsigned LCD_RS_BIT   = 8;
  localparam int unsigned LCD_ON_BIT   = 10;
  localparam int unsigned LCD_BLON_BIT = 11;
  localparam int unsigned LCD_WORD_W   = 12;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  // Commands 0x00-0x03 (clear and both home encodings) need the long execution wait.
  function automatic logic lcd_is_slow(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous write buffer between the LSU's LCD register and the panel sequencer.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module lcd_fifo
  import singlecycle_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = LCD_WORD_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: buffers CPU stores to the LCD register and replays each one
// with setup, EN pulse, hold and command-execution wait.
module lcd_ctrl
  import singlecycle_pkg::*;
#(
  parameter int unsigned T_AS_CYC   = 2,
  parameter int unsigned T_EN_CYC   = 12,
  parameter int unsigned T_AH_CYC   = 2,
  parameter int unsigned T_EXEC_CYC = 2000,
  parameter int unsigned T_CLR_CYC  = 82000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lcd_vld,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_LCD_DATA,
  output logic        o_LCD_RS,
  output logic        o_LCD_RW,
  output logic        o_LCD_EN,
  output logic        o_LCD_ON,
  output logic        o_LCD_BLON,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int unsigned CNT_W = $clog2(T_CLR_CYC + 1);

  lcd_state_e               r_state;
  lcd_state_e               w_state_d;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_d;
  logic                     r_en;
  logic                     w_en_d;
  logic [7:0]               r_data;
  logic                     r_rs;
  logic                     r_on;
  logic                     r_blon;
  logic                     r_overflow;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [LCD_WORD_W-1:0]    w_rdata;
  logic                     w_unused_bits;

  assign w_unused_bits = ^{i_lcd_word[31:LCD_WORD_W], w_rdata[9]};

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LCD_WORD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_lcd_vld),
    .i_wdata (i_lcd_word[LCD_WORD_W-1:0]),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Each timed state loads (duration - 1) on entry and leaves when the counter hits zero.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_en_d    = r_en;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StSetup;
          w_cnt_d   = CNT_W'(T_AS_CYC - 1);
        end
      end
      StSetup: begin
        if (r_cnt == '0) begin
          w_state_d = StPulse;
          w_en_d    = 1'b1;
          w_cnt_d   = CNT_W'(T_EN_CYC - 1);
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StPulse: begin
        if (r_cnt == '0) begin
          w_state_d = StHold;
          w_en_d    = 1'b0;
          w_cnt_d   = CNT_W'(T_AH_CYC - 1);
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StHold: begin
        if (r_cnt == '0) begin
          w_state_d = StWait;
          w_cnt_d   = lcd_is_slow(r_rs, r_data) ? CNT_W'(T_CLR_CYC - 1) : CNT_W'(T_EXEC_CYC - 1);
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_en_d    = 1'b0;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_en       <= 1'b0;
      r_data     <= '0;
      r_rs       <= 1'b0;
      r_on       <= 1'b0;
      r_blon     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_en    <= w_en_d;
      if (w_pop) begin
        r_data <= w_rdata[LCD_DATA_LSB +: 8];
        r_rs   <= w_rdata[LCD_RS_BIT];
        r_on   <= w_rdata[LCD_ON_BIT];
        r_blon <= w_rdata[LCD_BLON_BIT];
      end
      if (i_lcd_vld && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_LCD_DATA = r_data;
  assign o_LCD_RS   = r_rs;
  assign o_LCD_RW   = 1'b0;
  assign o_LCD_EN   = r_en;
  assign o_LCD_ON   = r_on;
  assign o_LCD_BLON = r_blon;
  assign o_busy     = !w_empty || (r_state != StIdle);
  assign o_overflow = r_overflow;

endmodule
